// File: rtl/apple_1_pia_pkg.sv
// Shared constants and helpers for the Apple-1 PIA responder.
package apple_1_pia_pkg;

  localparam logic [1:0] KBD   = 2'd0;
  localparam logic [1:0] KBDCR = 2'd1;
  localparam logic [1:0] DSP   = 2'd2;
  localparam logic [1:0] DSPCR = 2'd3;

  localparam logic [7:0] RD_DATA_RST  = 8'h00;
  localparam logic [6:0] DSP_DATA_RST = 7'h00;
  localparam logic [6:0] KCR_RST      = 7'h00;
  localparam logic [5:0] DCR_RST      = 6'h00;

  // Fold lowercase ASCII to uppercase; WozMon only understands uppercase.
  function automatic logic [6:0] case_fold(input logic [6:0] c);
    if (c >= 7'h61 && c <= 7'h7A) return c - 7'h20;
    return c;
  endfunction

endpackage

// File: rtl/apple_1_pia_fifo.sv
// Synchronous keyboard FIFO; push when full and pop when empty are ignored.
module apple_1_pia_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count, count_next;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) count_next = count + CW'(1);
    else if (!do_push && do_pop) count_next = count - CW'(1);
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/apple_1_pia.sv
// Apple-1 PIA bus target at BASE_ADDR..+3 with keyboard FIFO and display stream.
// Optional keyboard interrupt output IRQ_n is enabled by defining PIA_IRQ_EN.
module apple_1_pia
  import apple_1_pia_pkg::*;
#(
  parameter int unsigned KBD_FIFO_DEPTH = 4,
  parameter logic [15:0] BASE_ADDR      = 16'hD010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] AB,
  input  logic [7:0]  DO,
  input  logic        WE,
  input  logic        RDY,
  output logic [7:0]  rd_data,
  output logic        rd_sel,
  input  logic        kbd_valid,
  input  logic [6:0]  kbd_data,
  output logic        kbd_ready,
  output logic        dsp_valid,
  output logic [6:0]  dsp_data,
  input  logic        dsp_ready
`ifdef PIA_IRQ_EN
  ,
  output logic        IRQ_n
`endif
);

  logic       hit, rd_hit, wr_hit;
  logic [1:0] sel;
  logic [6:0] head;
  logic       full, empty;
  logic [6:0] kcr;
  logic [5:0] dcr;
  logic       ovr;
  logic [7:0] rd_next;
  logic       unused;

  assign unused = &{1'b0, DO[7]};

  assign hit    = RDY && (AB[15:2] == BASE_ADDR[15:2]);
  assign rd_hit = hit && !WE;
  assign wr_hit = hit && WE;
  assign sel    = AB[1:0];

  assign kbd_ready = !full;

  apple_1_pia_fifo #(
    .DEPTH (KBD_FIFO_DEPTH),
    .WIDTH (7)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (kbd_valid),
    .din   (case_fold(kbd_data)),
    .pop   (rd_hit && (sel == KBD)),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // Read mux; dsp_valid doubles as the display busy flag.
  always_comb begin
    rd_next = RD_DATA_RST;
    if (rd_hit) begin
      case (sel)
        KBD:     rd_next = empty ? 8'h80 : {1'b1, head};
        KBDCR:   rd_next = {!empty, kcr};
        DSP:     rd_next = {dsp_valid, dsp_data};
        default: rd_next = {1'b0, ovr, dcr};
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data   <= RD_DATA_RST;
      rd_sel    <= 1'b0;
      kcr       <= KCR_RST;
      dcr       <= DCR_RST;
      ovr       <= 1'b0;
      dsp_valid <= 1'b0;
      dsp_data  <= DSP_DATA_RST;
    end else begin
      rd_data <= rd_next;
      rd_sel  <= rd_hit;
      if (wr_hit && sel == KBDCR) kcr <= DO[6:0];
      if (wr_hit && sel == DSPCR) dcr <= DO[5:0];
      if (rd_hit && sel == DSPCR) ovr <= 1'b0;
      if (dsp_valid && dsp_ready) dsp_valid <= 1'b0;
      // A write landing while busy is lost, even if the host accepts this cycle.
      if (wr_hit && sel == DSP) begin
        if (!dsp_valid) begin
          dsp_data  <= DO[6:0];
          dsp_valid <= 1'b1;
        end else begin
          ovr <= 1'b1;
        end
      end
    end
  end

`ifdef PIA_IRQ_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) IRQ_n <= 1'b1;
    else        IRQ_n <= !(kcr[0] && !empty);
  end
`endif

endmodule

// File: tb/tb_apple_1_pia.sv
// Randomised scoreboard bench for apple_1_pia against a queue-based register model.
module tb_apple_1_pia;

  localparam int unsigned DEPTH = 4;
  localparam logic [15:0] BASE  = 16'hD010;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] AB;
  logic [7:0]  DO;
  logic        WE, RDY;
  logic [7:0]  rd_data;
  logic        rd_sel;
  logic        kbd_valid;
  logic [6:0]  kbd_data;
  logic        kbd_ready;
  logic        dsp_valid;
  logic [6:0]  dsp_data;
  logic        dsp_ready;
`ifdef PIA_IRQ_EN
  logic        IRQ_n;
`endif

  apple_1_pia #(.KBD_FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .AB        (AB),
    .DO        (DO),
    .WE        (WE),
    .RDY       (RDY),
    .rd_data   (rd_data),
    .rd_sel    (rd_sel),
    .kbd_valid (kbd_valid),
    .kbd_data  (kbd_data),
    .kbd_ready (kbd_ready),
    .dsp_valid (dsp_valid),
    .dsp_data  (dsp_data),
    .dsp_ready (dsp_ready)
`ifdef PIA_IRQ_EN
    ,
    .IRQ_n     (IRQ_n)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard of expected read data, plus the behavioural register model.
  logic [7:0] exp_q[$];
  bit [6:0]   kq[$];
  bit         m_busy;
  bit [6:0]   m_dsp;
  bit         m_ovr;
  bit [6:0]   m_kcr;
  bit [5:0]   m_dcr;

  function automatic bit [6:0] fold(input bit [6:0] k);
    return (k >= 7'h61 && k <= 7'h7A) ? k - 7'h20 : k;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    kq.delete();
    exp_q.delete();
    m_busy = 0; m_dsp = '0; m_ovr = 0; m_kcr = '0; m_dcr = '0;
  endtask

  // Monitor: every rd_sel must match the oldest outstanding read expectation.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (rd_sel === 1'b1) begin
        if (exp_q.size() == 0) check("rd_sel_unexpected", 32'(rd_sel), 32'd0);
        else check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end else begin
        check("rd_idle", 32'(rd_data), 32'd0);
      end
    end
  end

  // Drive one bus/host cycle, update the model, then check status outputs.
  task automatic cycle(input logic [15:0] a, input bit we, input logic [7:0] d,
                       input bit rdy, input bit kv, input logic [6:0] kd, input bit dr);
    bit         hit, full, accept;
    logic [7:0] rv;
    bit         irq_exp;
    AB = a; WE = we; DO = d; RDY = rdy; kbd_valid = kv; kbd_data = kd; dsp_ready = dr;
    hit     = rdy && (a[15:2] == BASE[15:2]);
    irq_exp = !(m_kcr[0] && kq.size() != 0);
    full    = (kq.size() == DEPTH);
    accept  = m_busy && dr;
    if (hit && !we) begin
      case (a[1:0])
        2'd0:    rv = (kq.size() == 0) ? 8'h80 : {1'b1, kq[0]};
        2'd1:    rv = {kq.size() != 0, m_kcr};
        2'd2:    rv = {m_busy, m_dsp};
        default: rv = {1'b0, m_ovr, m_dcr};
      endcase
      exp_q.push_back(rv);
      if (a[1:0] == 2'd0 && kq.size() != 0) void'(kq.pop_front());
      if (a[1:0] == 2'd3) m_ovr = 0;
    end
    if (kv && !full) kq.push_back(fold(kd));
    if (accept) m_busy = 0;
    if (hit && we) begin
      case (a[1:0])
        2'd1: m_kcr = d[6:0];
        2'd3: m_dcr = d[5:0];
        2'd2: if (accept || m_busy) m_ovr = 1;
              else begin m_dsp = d[6:0]; m_busy = 1; end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    check("kbd_ready", 32'(kbd_ready), 32'(kq.size() != DEPTH));
    check("dsp_valid", 32'(dsp_valid), 32'(m_busy));
    check("dsp_data", 32'(dsp_data), 32'(m_dsp));
`ifdef PIA_IRQ_EN
    check("irq_n", 32'(IRQ_n), 32'(irq_exp));
`endif
  endtask

  task automatic rd(input logic [1:0] r);
    cycle(BASE + 16'(r), 0, 8'h00, 1, 0, 7'h00, 0);
  endtask

  task automatic wr(input logic [1:0] r, input logic [7:0] d, input bit dr);
    cycle(BASE + 16'(r), 1, d, 1, 0, 7'h00, dr);
  endtask

  task automatic key(input logic [6:0] k);
    cycle(16'h0000, 0, 8'h00, 1, 1, k, 0);
  endtask

  task automatic idle(input bit dr);
    cycle(16'h0000, 0, 8'h00, 1, 0, 7'h00, dr);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_sel"},    32'(rd_sel),    32'd0);
    check({tag, "_rd_data"},   32'(rd_data),   32'd0);
    check({tag, "_dsp_valid"}, 32'(dsp_valid), 32'd0);
    check({tag, "_dsp_data"},  32'(dsp_data),  32'd0);
    check({tag, "_kbd_ready"}, 32'(kbd_ready), 32'd1);
`ifdef PIA_IRQ_EN
    check({tag, "_irq_n"},     32'(IRQ_n),     32'd1);
`endif
  endtask

  initial begin
    logic [15:0] a;
    int unsigned r;
    reset = 1'b0;
    AB = '0; DO = '0; WE = 0; RDY = 0; kbd_valid = 0; kbd_data = '0; dsp_ready = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b1;

    // Reset state and key path
    rd(2'd1);
    key(7'h61);
    rd(2'd1);
    rd(2'd0);
    rd(2'd1);

    // FIFO full: fifth key is refused
    for (int i = 0; i < 5; i++) key(7'(7'h41 + i));
    for (int i = 0; i < 5; i++) rd(2'd0);

    // Display path and overrun flag
    wr(2'd2, 8'hB0, 0);
    rd(2'd2);
    wr(2'd2, 8'hC1, 0);
    rd(2'd3);
    rd(2'd3);
    idle(1);
    idle(0);
    // Host accepts in the same cycle as a CPU write: write lost, ovr set
    wr(2'd2, 8'hB5, 0);
    wr(2'd2, 8'hB6, 1);
    rd(2'd3);
    rd(2'd2);

`ifdef PIA_IRQ_EN
    wr(2'd1, 8'h01, 0);
    key(7'h71);
    idle(0);
    rd(2'd0);
    idle(0);
    idle(0);
`endif

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      a = (r < 8) ? BASE + 16'(r[1:0]) : 16'($urandom);
      cycle(a, $urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 7) != 0,
            $urandom_range(0, 2) == 0, 7'($urandom), $urandom_range(0, 3) == 0);
    end
    idle(0);

    // Mid-operation reset with keys queued and the display busy
    idle(1);
    key(7'h31);
    key(7'h32);
    wr(2'd2, 8'hB3, 0);
    wr(2'd1, 8'h7F, 0);
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_clear();
    AB = '0; WE = 0; RDY = 0; kbd_valid = 0; dsp_ready = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    rd(2'd1);
    rd(2'd0);
    idle(0);
    idle(0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apple_1_pia.md
# apple_1_pia

Memory-mapped keyboard/display responder for the Apple-1 WozMon system, sitting on the CPU side of the 6502 bus (AB/DO/WE/RDY) and answering at $D010–$D013 as the Apple-1 PIA does. It returns registered read data to the system DI mux and applies read/write side effects. On the host side it exposes a valid/ready keyboard input stream with a small FIFO and a valid/ready display output stream. It is the bus target that services WozMon's KBD/KBDCR/DSP/DSPCR polling loop.

## Interface
- KBD_FIFO_DEPTH, default 4, keyboard FIFO entries; power of two, 2..16
- BASE_ADDR, default 16'hD010, register base; bits [1:0] must be 0
- clk  in  1  CPU clock; all logic rising-edge
- reset  in  1  asynchronous, active-low reset
- AB  in  16  CPU address bus
- DO  in  8  CPU write data
- WE  in  1  CPU write enable
- RDY  in  1  CPU ready; bus cycles with RDY=0 are ignored
- rd_data  out  8  registered read data for the DI mux
- rd_sel  out  1  registered; rd_data is valid for DI this cycle
- kbd_valid  in  1  host key available
- kbd_data  in  7  host ASCII key
- kbd_ready  out  1  FIFO can accept a key (= !full)
- dsp_valid  out  1  character pending for host
- dsp_data  out  7  pending display character
- dsp_ready  in  1  host accepts character
- IRQ_n  out  1  active-low keyboard interrupt (only with PIA_IRQ_EN)

## Operation
- Hit: AB[15:2]==BASE_ADDR[15:2] and RDY=1. Register select = AB[1:0].
- Reads (WE=0): rd_data/rd_sel registered on the hit cycle, valid on the next cycle. Non-hit or RDY=0 cycles drive rd_sel=0, rd_data=8'h00.
  - 0 KBD: {1'b1, FIFO head}. Pops the FIFO if non-empty. Empty FIFO returns 8'h80, no pop.
  - 1 KBDCR: {!empty, kcr[6:0]}.
  - 2 DSP: {dsp_busy, dsp_data}.
  - 3 DSPCR: {1'b0, ovr, dcr[5:0]}. Reading clears the sticky ovr flag.
- Writes (WE=1):
  - 1 KBDCR: kcr ← DO[6:0].
  - 3 DSPCR: dcr ← DO[5:0].
  - 2 DSP:
    - If !dsp_busy: dsp_data ← DO[6:0], dsp_busy ← 1.
    - Otherwise the write is dropped and ovr ← 1.
  - Writes to 0 are ignored.
- Keyboard push: on kbd_valid && kbd_ready, write kbd_data to the FIFO tail. Lowercase 7'h61–7'h7A is stored minus 7'h20. All other codes are stored unchanged.
- Display handshake:
  - dsp_valid = dsp_busy.
  - On dsp_valid && dsp_ready, dsp_busy clears at the next edge.
  - dsp_data holds its value until the next accepted CPU write.

## Timing
- All registers reset to 0:
  - outputs: rd_data=0, rd_sel=0, dsp_valid=0, dsp_data=0
  - kbd_ready=1, IRQ_n=1
  - FIFO pointers/count, kcr, dcr and ovr cleared
- Read latency 1 cycle. Side effects (pop, ovr clear) take effect at the same edge that registers rd_data.
- kbd_ready is registered from the FIFO count:
  - A full FIFO does not accept a push even if a pop happens in the same cycle.
  - Push and pop in the same non-full, non-empty cycle leave the count unchanged.
- Push into an empty FIFO: KBDCR bit7 reads 1 starting with a read hit one cycle after the push edge.
- CPU DSP write and host acceptance in the same cycle: busy is still 1, so the write is dropped and ovr is set. Busy clears at that edge.
- FIFO pointers wrap modulo KBD_FIFO_DEPTH. Count is $clog2(DEPTH)+1 bits wide.
- Async reset mid-transfer discards FIFO contents and any pending display character. No handshake completes on the reset edge.

## Configuration
- PIA_IRQ_EN defined:
  - Instantiate IRQ_n = !(kcr[0] && !empty), registered.
  - IRQ_n deasserts the cycle after the pop that empties the FIFO.
- PIA_IRQ_EN undefined:
  - IRQ_n is absent.
  - kcr[0] is plain storage.

## Structure
- Shared package apple_1_pia_pkg holds:
  - register offset constants KBD=2'd0, KBDCR=2'd1, DSP=2'd2, DSPCR=2'd3
  - the case-fold function
  - the reset value constants
- One sub-module, apple_1_pia_fifo: parameterised synchronous FIFO with push/pop/full/empty/head. The top level holds the bus decode, DSP state and optional IRQ.

## Test plan
- Reset: deassert reset, idle bus. Required: rd_sel=0, dsp_valid=0, kbd_ready=1, IRQ_n=1; KBDCR read returns 8'h00.
- Key path:
  - Push 7'h61 ('a'). Read $D011 → 8'h80. Read $D010 → 8'hC1.
  - Read $D011 again → 8'h00.
- FIFO full: push 5 keys with DEPTH=4.
  - kbd_ready=0 after the 4th key; the 5th is not accepted.
  - Four KBD reads return the keys in order. A fifth read returns 8'h80.
- Display:
  - Write $D012←8'hB0 with dsp_ready=0. Required: dsp_valid=1, dsp_data=7'h30. Read $D012 → 8'hB0.
  - Second write sets ovr; $D013 read → bit6=1, then a repeat read → bit6=0.
  - Raise dsp_ready: dsp_valid falls one cycle later.
- IRQ (PIA_IRQ_EN): write $D011←8'h01, push a key → IRQ_n=0. Read $D010 → IRQ_n=1 next cycle.
- Mid-operation reset: reset asserted with 2 keys queued and dsp_busy=1. Required: outputs return to reset values immediately and KBDCR reads 8'h00 afterwards.
